pilha_lifo: RTL

- Downstream stage of the 8-bit deserializer: consumes its words through a 4-phase data_ready/ack handshake that crosses clock domains, and pushes each word onto a LIFO stack.
- Runs entirely on its own clock clk. The deserializer side (data_in, data_ready_in) is asynchronous to clk.
- Words are popped locally by the stack-domain consumer via pop_in.

---
 rtl/pilha_pkg.sv | 20 ++
 rtl/sync_bit.sv | 31 +++
 rtl/pilha_lifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pilha_pkg.sv
// +----------------------------------------------------------------------+
// | pilha_pkg                                                            |
// | Shared types and default sizes for the pilha_lifo stack block.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package pilha_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } hs_state_t;

    localparam int WORD_W      = 8;
    localparam int STACK_DEPTH = 8;

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// +----------------------------------------------------------------------+
// | sync_bit                                                             |
// | Multi-flop synchronizer bringing one asynchronous bit into clk.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d_in};
        end
    end

    assign q_out = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pilha_lifo.sv
// +----------------------------------------------------------------------+
// | pilha_lifo                                                           |
// | LIFO stack fed by a 4-phase ready/ack handshake from another domain. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pilha_lifo
    import pilha_pkg::*;
#(
    parameter int WIDTH       = WORD_W,
    parameter int DEPTH       = STACK_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       data_ready_in,
    output logic                       ack_out,
    input  logic                       pop_in,
    output logic [WIDTH-1:0]           top_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic                       underflow_out
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    hs_state_t          r_state;
    hs_state_t          w_state_next;
    logic               r_ack;
    logic               w_ack_next;
    logic               w_rdy_s;
    logic               w_push;
    logic               w_pop_eff;
    logic               w_empty;
    logic               w_full;
    logic [c_CNT_W-1:0] r_count;
    logic [c_ADDR_W-1:0] w_top_idx;
    logic [c_ADDR_W-1:0] w_wr_idx;
    logic               r_underflow;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ready (
        .clk   (clk),
        .reset (reset),
        .d_in  (data_ready_in),
        .q_out (w_rdy_s)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // Handshake state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
        end
    end

    // Push only from IDLE; a full stack stalls the deserializer on its word.
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = r_ack;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rdy_s && !w_full) begin
                    w_push       = 1'b1;
                    w_ack_next   = 1'b1;
                    w_state_next = ACKED;
                end
            end
            ACKED: begin
                if (!w_rdy_s) begin
                    w_ack_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_ack_next   = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_pop_eff = pop_in && !w_empty;
    assign w_top_idx = c_ADDR_W'(r_count - c_CNT_W'(1));
    assign w_wr_idx  = c_ADDR_W'(r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push && !w_pop_eff) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop_eff && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            r_underflow <= pop_in && w_empty && !w_push;
        end
    end

    // Push with a simultaneous pop replaces the current top in place.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_pop_eff) begin
                r_mem[w_top_idx] <= data_in;
            end else begin
                r_mem[w_wr_idx] <= data_in;
            end
        end
    end

    assign ack_out       = r_ack;
    assign count_out     = r_count;
    assign empty_out     = w_empty;
    assign full_out      = w_full;
    assign underflow_out = r_underflow;
    assign top_out       = w_empty ? '0 : r_mem[w_top_idx];

endmodule

`default_nettype wire
